// File: rtl/pulse_profile_gen.sv
// Step pulse generator: three preset half-period dividers or a table-driven multi-segment profile, plus a free-running 1 Hz strobe.
// Define PROFILE_LOOP_EN to make the profile wrap to segment 0 forever instead of finishing in DONE.
module pulse_profile_gen #(
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned DUR_W       = 8,
  parameter int unsigned SEG_AW      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned PRESET0_DIV = 1562500,
  parameter int unsigned PRESET1_DIV = 781250,
  parameter int unsigned PRESET2_DIV = 390625
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [SEG_AW:0]   prof_len,
  input  logic              seg_we,
  input  logic [SEG_AW-1:0] seg_addr,
  input  logic [DIV_W-1:0]  seg_div,
  input  logic [DUR_W-1:0]  seg_dur,
  output logic              pulse,
  output logic              tick_1hz,
  output logic              busy,
  output logic              done,
  output logic [SEG_AW-1:0] cur_seg,
  output logic [CNT_W-1:0]  pulse_cnt
);

  localparam int unsigned DEPTH = 2 ** SEG_AW;
  localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);
  localparam logic [SEG_AW:0]  SEG_ONE = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_FIX  = 2'd1,
    RUN_PROF = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  half_q, half_d;
  logic              pulse_q, pulse_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DUR_W-1:0]  sec_q, sec_d;
  logic [SEG_AW-1:0] cur_seg_q, cur_seg_d;
  logic [SEG_AW:0]   prof_len_q, prof_len_d;
  logic [DIV_W-1:0]  fix_div_q, fix_div_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  pulse_cnt_q, pulse_cnt_d;
  logic [PRE_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic              tick_q, tick_d;

  // Segment table: distributed RAM read asynchronously so a new segment's rate applies on its first cycle.
  logic [DIV_W-1:0] div_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem [DEPTH];
  logic [DIV_W-1:0] rd_div;
  logic [DUR_W-1:0] rd_dur;
  logic             running;

  assign running = (state_q == RUN_FIX) || (state_q == RUN_PROF);
  assign rd_div  = div_mem[cur_seg_q];
  assign rd_dur  = dur_mem[cur_seg_q];

  always_ff @(posedge clk) begin
    if (seg_we && !running) begin
      div_mem[seg_addr] <= seg_div;
      dur_mem[seg_addr] <= seg_dur;
    end
  end

  logic [DIV_W-1:0] act_div;
  logic [DIV_W-1:0] step_half;
  logic             step_pulse;
  logic             seg_expire;
  logic             seg_last;

  always_comb begin
    act_div    = (state_q == RUN_PROF) ? rd_div : fix_div_q;
    step_half  = half_q + DIV_W'(1);
    step_pulse = pulse_q;
    if (act_div == '0) begin
      step_half  = '0;
      step_pulse = 1'b0;
    end else if (half_q == act_div - DIV_W'(1)) begin
      step_half  = '0;
      step_pulse = ~pulse_q;
    end
    // A zero-length segment expires on its first cycle.
    seg_expire = (rd_dur == '0) || ((pre_q == PRE_MAX) && (sec_q == rd_dur - DUR_W'(1)));
    seg_last   = (({1'b0, cur_seg_q} + SEG_ONE) == prof_len_q);
  end

  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    pulse_d     = pulse_q;
    pre_d       = pre_q;
    sec_d       = sec_q;
    cur_seg_d   = cur_seg_q;
    prof_len_d  = prof_len_q;
    fix_div_d   = fix_div_q;
    done_d      = done_q;
    pulse_cnt_d = pulse_cnt_q;

    case (state_q)
      IDLE, DONE: begin
        half_d  = '0;
        pulse_d = 1'b0;
        pre_d   = '0;
        sec_d   = '0;
        if (start && !stop) begin
          done_d      = 1'b0;
          pulse_cnt_d = '0;
          cur_seg_d   = '0;
          prof_len_d  = prof_len;
          if (mode != 2'd3) begin
            state_d = RUN_FIX;
            case (mode)
              2'd0:    fix_div_d = DIV_W'(PRESET0_DIV);
              2'd1:    fix_div_d = DIV_W'(PRESET1_DIV);
              default: fix_div_d = DIV_W'(PRESET2_DIV);
            endcase
          end else if (prof_len != '0) begin
            state_d = RUN_PROF;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      RUN_FIX: begin
        if (stop) begin
          state_d = IDLE;
          half_d  = '0;
          pulse_d = 1'b0;
        end else begin
          half_d  = step_half;
          pulse_d = step_pulse;
        end
      end

      RUN_PROF: begin
        if (stop) begin
          state_d = IDLE;
          half_d  = '0;
          pulse_d = 1'b0;
          pre_d   = '0;
          sec_d   = '0;
        end else if (seg_expire) begin
          half_d  = '0;
          pulse_d = 1'b0;
          pre_d   = '0;
          sec_d   = '0;
          if (seg_last) begin
`ifdef PROFILE_LOOP_EN
            cur_seg_d = '0;
`else
            state_d = DONE;
            done_d  = 1'b1;
`endif
          end else begin
            cur_seg_d = cur_seg_q + SEG_AW'(1);
          end
        end else begin
          half_d  = step_half;
          pulse_d = step_pulse;
          if (pre_q == PRE_MAX) begin
            pre_d = '0;
            sec_d = sec_q + DUR_W'(1);
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (pulse_d && !pulse_q && (pulse_cnt_q != {CNT_W{1'b1}})) begin
      pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
    end
  end

  // The 1 Hz strobe runs from reset regardless of the FSM.
  always_comb begin
    tick_d     = (tick_cnt_q == PRE_MAX);
    tick_cnt_d = (tick_cnt_q == PRE_MAX) ? '0 : tick_cnt_q + PRE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      half_q      <= '0;
      pulse_q     <= 1'b0;
      pre_q       <= '0;
      sec_q       <= '0;
      cur_seg_q   <= '0;
      prof_len_q  <= '0;
      fix_div_q   <= '0;
      done_q      <= 1'b0;
      pulse_cnt_q <= '0;
      tick_cnt_q  <= '0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      pulse_q     <= pulse_d;
      pre_q       <= pre_d;
      sec_q       <= sec_d;
      cur_seg_q   <= cur_seg_d;
      prof_len_q  <= prof_len_d;
      fix_div_q   <= fix_div_d;
      done_q      <= done_d;
      pulse_cnt_q <= pulse_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      tick_q      <= tick_d;
    end
  end

  assign pulse     = pulse_q;
  assign tick_1hz  = tick_q;
  assign busy      = running;
  assign done      = done_q;
  assign cur_seg   = cur_seg_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule

// File: doc/pulse_profile_gen.md
Name: pulse_profile_gen

Overview:
Parametrised successor to the lab stepper pulse generator. Produces a 50%-duty step pulse whose half-period comes from one of three preset dividers or from a loadable multi-segment speed profile. Each profile segment holds a rate for an exact number of seconds. Sits between the mode/start controls and the motor driver, and also supplies a free-running 1 Hz strobe for display logic.

Parameters:
CLK_HZ, 100000000, system clock frequency; one "second" is CLK_HZ cycles
DIV_W, 32, width of half-period divider values
DUR_W, 8, width of segment duration in seconds
SEG_AW, 4, segment table address width; depth = 2**SEG_AW
CNT_W, 16, width of the pulse edge counter
PRESET0_DIV, 1562500, half-period for mode 0 (32 Hz)
PRESET1_DIV, 781250, half-period for mode 1 (64 Hz)
PRESET2_DIV, 390625, half-period for mode 2 (128 Hz)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle start request
stop  in  1  one-cycle abort request
mode  in  2  0..2 = presets, 3 = profile; sampled only on an accepted start
prof_len  in  SEG_AW+1  number of profile segments used (0..2**SEG_AW); sampled on start
seg_we  in  1  table write strobe
seg_addr  in  SEG_AW  table write address
seg_div  in  DIV_W  segment half-period
seg_dur  in  DUR_W  segment duration in seconds
pulse  out  1  step pulse
tick_1hz  out  1  one-cycle strobe every CLK_HZ cycles
busy  out  1  high while running
done  out  1  profile completed; held until next start or rst
cur_seg  out  SEG_AW  active segment index
pulse_cnt  out  CNT_W  rising edges of pulse since start; saturates at all-ones

Behaviour:
- Reset: FSM in IDLE. pulse, tick_1hz, busy, done = 0. cur_seg, pulse_cnt and all counters = 0. Table contents are not reset.
- FSM states: IDLE, RUN_FIX, RUN_PROF, DONE.
- IDLE/DONE + start:
  - mode<3 goes to RUN_FIX.
  - mode==3 with prof_len>0 goes to RUN_PROF at segment 0.
  - mode==3 with prof_len==0 goes directly to DONE.
  - Any start clears done and pulse_cnt.
- start while busy is ignored. mode and prof_len changes while busy are ignored.
- stop in RUN_*: return to IDLE next cycle. pulse forced 0 that cycle. done stays 0.
- stop and start in the same cycle: stop wins.
- Divider:
  - Half-counter resets to 0 on state entry and on each segment change.
  - It counts each cycle. When it reaches div-1 it wraps to 0 and pulse toggles.
  - First rising edge occurs div cycles after entering RUN.
  - pulse is always 0 outside RUN_*.
  - div==0: pulse held 0 and counter held at 0.
  - div==1: pulse toggles every cycle.
- Segment timer:
  - In RUN_PROF, a prescaler counts CLK_HZ cycles and a second counter counts elapsed seconds.
  - Segment k lasts exactly seg_dur[k]*CLK_HZ cycles.
  - On expiry, cur_seg increments, both counters clear, pulse restarts low, and the new div applies immediately.
  - seg_dur==0: segment lasts one cycle with pulse low, then advances.
  - After the expiry of segment prof_len-1, go to DONE: done=1, busy=0, pulse=0.
- Table writes are accepted in IDLE/DONE only. seg_we is ignored while busy.
- tick_1hz is free-running from reset: it pulses on cycles CLK_HZ, 2*CLK_HZ, ... after reset release and is independent of the FSM.
- busy = 1 in RUN_FIX and RUN_PROF.
- pulse_cnt increments on each 0->1 transition of pulse and saturates at all-ones.
- rst mid-run returns to the reset state on the next edge.

Optional Feature:
PROFILE_LOOP_EN:
- Defined: after the last segment, RUN_PROF wraps to segment 0 instead of entering DONE. done never asserts in mode 3. The run ends only by stop or rst.
- Undefined: the profile terminates in DONE as described above.

Test Plan:
All scenarios use CLK_HZ=100.
1. Reset then idle for 350 cycles -> tick_1hz high for exactly one cycle at cycles 100, 200, 300; pulse=0, busy=0.
2. Preset timing: PRESET0_DIV=5, mode=0, start at cycle T -> busy=1 at T+1; pulse rises at T+6, falls at T+11; pulse_cnt=3 after 30 run cycles.
3. Profile: seg0={div 2, dur 1}, seg1={div 4, dur 2}, prof_len=2, mode=3 -> 25 pulses in seg0, then cur_seg=1 with 25 pulses in 200 cycles; done=1 and pulse=0 at 300 cycles after start; pulse_cnt=50.
4. Boundary cases:
   - prof_len=0 start -> done=1 next cycle.
   - A seg_dur=0 segment -> skipped after one cycle.
   - div=0 segment -> pulse stays 0 for the whole segment.
5. Start mid-run, then stop -> mid-run start is ignored; stop gives IDLE next cycle with pulse=0 and done=0; seg_we while busy leaves the table unchanged (read back via a later run).
6. With PROFILE_LOOP_EN: the 2-segment profile from scenario 3 -> cur_seg wraps 1->0 at cycle 300, done stays 0, and a stop ends the run.
